spi_move_receiver: RTL

SPI_MOVE_RECEIVER -- requirements
Module: spi_move_receiver

---
 rtl/spi_move_receiver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/spi_move_receiver.sv
// SPI move receiver: synchronizes a player-2 SPI byte stream into the clk domain,
// validates each 8-bit frame and holds the selected column until acknowledged.
module spi_move_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  HEADER      = 3'b101,
    parameter int unsigned MAX_COL     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    input  logic       enable,
    input  logic       move_ack,
    output logic [2:0] selected_col,
    output logic       valid_move,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam logic [2:0] MAX_COL_3 = 3'(MAX_COL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK,
        S_HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_selected_col;
    logic       r_valid_move;
    logic       r_frame_err;
    logic [7:0] r_err_count;

    logic w_sclk_s;
    logic w_mosi_s;
    logic w_cs_s;
    logic w_strobe;
    logic w_cs_fall;
    logic w_accept;

    // Saturating increment for the rejected-frame counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Multi-stage synchronizers plus previous-value registers for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync[0] <= spi_clk;
            r_mosi_sync[0] <= spi_mosi;
            r_cs_sync[0]   <= spi_cs;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i] <= r_sclk_sync[i-1];
                r_mosi_sync[i] <= r_mosi_sync[i-1];
                r_cs_sync[i]   <= r_cs_sync[i-1];
            end
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_strobe  = w_sclk_s & ~r_sclk_prev;
    assign w_cs_fall = ~w_cs_s & r_cs_prev;

    // Frame acceptance: header, reserved zero bits, legal column, moves enabled
    assign w_accept = (r_shift[7:5] == HEADER) && (r_shift[4:3] == 2'b00) &&
                      (r_shift[2:0] <= MAX_COL_3) && enable;

    // Frame FSM with registered move/error outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_shift        <= 8'd0;
            r_bit_cnt      <= 3'd0;
            r_selected_col <= 3'd0;
            r_valid_move   <= 1'b0;
            r_frame_err    <= 1'b0;
            r_err_count    <= 8'd0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_shift   <= 8'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // The 8th strobe wins over a simultaneous cs rise
                    if (w_strobe && (r_bit_cnt == 3'd7)) begin
                        r_shift   <= {r_shift[6:0], w_mosi_s};
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_CHECK;
                    end else if (w_cs_s) begin
                        r_frame_err <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                        r_state     <= S_IDLE;
                    end else if (w_strobe) begin
                        r_shift   <= {r_shift[6:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        r_selected_col <= r_shift[2:0];
                        r_valid_move   <= 1'b1;
                        r_state        <= S_HOLD;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_err_count <= sat_inc(r_err_count);
                        r_state     <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // IDLE only restarts on a cs fall, so a low cs simply waits there
                    if (!enable || move_ack) begin
                        r_valid_move <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign selected_col = r_selected_col;
    assign valid_move   = r_valid_move;
    assign frame_err    = r_frame_err;
    assign err_count    = r_err_count;

endmodule
